if_fetch_unit: RTL

- Instruction-fetch stage of the ARM pipeline; sits directly upstream of the decode stage and produces its instruction/PC through an internal IF/ID register.
- Holds the PC and issues requests to a variable-latency instruction memory over a req/ack handshake.
- Obeys freeze from the hazard unit and redirects/flushes on branch_taken from EXE.

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_fetch_unit_if.sv | 10 +
 rtl/if_fetch_unit_if_id_reg.sv | 37 +++
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    START   = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] FLUSH_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] WORD_INC        = 32'd4;
  localparam logic [31:0] WORD_MASK       = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and memory.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats bubble, otherwise hold.
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] FLUSH_INSTR = FLUSH_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        bubble,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= FLUSH_INSTR;
      pc_out      <= '0;
      valid       <= 1'b0;
    end else if (flush) begin
      // pc_out deliberately kept so decode still sees the last real PC
      instruction <= FLUSH_INSTR;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= next_instr;
      pc_out      <= next_pc;
      valid       <= 1'b1;
    end else if (bubble) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC, variable-latency imem handshake, freeze buffer and branch redirect.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] FLUSH_INSTR = FLUSH_INSTR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_address,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            pc_out,
  output logic [31:0]            instruction,
  output logic                   valid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         fetch_req;
  logic [31:0]  fetch_addr;
  logic [31:0]  buf_instr;
  logic [31:0]  buf_pc;
  logic [31:0]  target;
  logic [31:0]  addr_next;

  logic         load;
  logic         flush;
  logic         bubble;
  logic [31:0]  next_instr;
  logic [31:0]  next_pc;

  assign imem.imem_req  = fetch_req;
  assign imem.imem_addr = fetch_addr;
  assign target         = align_word(branch_address);
  assign addr_next      = fetch_addr + WORD_INC;

  always_comb begin
    flush      = branch_taken;
    load       = 1'b0;
    bubble     = 1'b0;
    next_instr = imem.imem_rdata;
    next_pc    = addr_next;
    case (state)
      FETCH: begin
        load   = !freeze && imem.imem_ack;
        bubble = !freeze && !imem.imem_ack;
      end
      HOLD: begin
        load       = !freeze;
        next_instr = buf_instr;
        next_pc    = buf_pc;
      end
      DISCARD: bubble = !freeze;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= START;
      fetch_req  <= 1'b0;
      fetch_addr <= RESET_PC;
      pc         <= RESET_PC;
      buf_instr  <= FLUSH_INSTR;
      buf_pc     <= '0;
    end else begin
      case (state)
        START: begin
          state     <= FETCH;
          fetch_req <= 1'b1;
          if (branch_taken) begin
            pc         <= target;
            fetch_addr <= target;
          end else begin
            fetch_addr <= pc;
          end
        end
        FETCH: begin
          if (branch_taken) begin
            pc <= target;
            // without an ack the old request is still in flight and must be waited out
            if (imem.imem_ack) fetch_addr <= target;
            else               state      <= DISCARD;
          end else if (imem.imem_ack) begin
            pc <= addr_next;
            if (freeze) begin
              buf_instr <= imem.imem_rdata;
              buf_pc    <= addr_next;
              state     <= HOLD;
              fetch_req <= 1'b0;
            end else begin
              fetch_addr <= addr_next;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc         <= target;
            fetch_addr <= target;
            buf_instr  <= FLUSH_INSTR;
            buf_pc     <= '0;
            state      <= FETCH;
            fetch_req  <= 1'b1;
          end else if (!freeze) begin
            fetch_addr <= pc;
            state      <= FETCH;
            fetch_req  <= 1'b1;
          end
        end
        DISCARD: begin
          if (branch_taken) pc <= target;
          if (imem.imem_ack) begin
            fetch_addr <= branch_taken ? target : pc;
            state      <= FETCH;
          end
        end
        default: begin
          state     <= START;
          fetch_req <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .FLUSH_INSTR (FLUSH_INSTR)
  ) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .flush       (flush),
    .bubble      (bubble),
    .next_instr  (next_instr),
    .next_pc     (next_pc),
    .instruction (instruction),
    .pc_out      (pc_out),
    .valid       (valid)
  );

endmodule
